// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch stage.
//   NOP_INSTR      - canonical bubble instruction (addi x0,x0,0)
//   ifetch_state_t - fetch FSM states
//   entry_flags_t  - per-entry status bits of the in-flight queue
package ifetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } ifetch_state_t;

    // pc/instr payloads are XLEN wide and live in parameterised arrays next
    // to these flags inside ifetch_queue.
    typedef struct packed {
        logic filled;
        logic squash;
    } entry_flags_t;

endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order circular buffer of in-flight fetches.
// Ports:
//   clk, rst                 clock, async active-high reset
//   alloc, alloc_pc          allocate a new unfilled entry for alloc_pc
//   fill, fill_data          memory response for the oldest unfilled entry
//   pop                      retire the head entry into IF/ID
//   squash_all               mark every entry squashed; filled ones are freed
//   head_pc/instr/filled/squash  view of the oldest entry
//   fill_pending             at least one entry still awaits its response
//   full, empty              occupancy status
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_data,
    input  logic            pop,
    input  logic            squash_all,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr,
    output logic            head_filled,
    output logic            head_squash,
    output logic            fill_pending,
    output logic            full,
    output logic            empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] instr_q [DEPTH];
    entry_flags_t    flags_q [DEPTH];

    logic [PW-1:0] head_ptr, fill_ptr, alloc_ptr;
    logic [CW-1:0] count_q, pend_q, free_n;
    logic          fill_hit, fill_sq;

    // Filled entries always sit at the head and squashed entries precede
    // live ones, so every free is a head advance.
    always_comb begin
        fill_hit = fill & (pend_q != '0);
        fill_sq  = fill_hit & flags_q[fill_ptr].squash;
        if (squash_all)
            free_n = (count_q - pend_q) + CW'(fill_hit);
        else
            free_n = CW'(pop | fill_sq);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr  <= '0;
            fill_ptr  <= '0;
            alloc_ptr <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            for (int i = 0; i < DEPTH; i++) flags_q[i] <= '0;
        end else begin
            head_ptr  <= PW'(head_ptr + free_n);
            fill_ptr  <= fill_ptr + PW'(fill_hit);
            alloc_ptr <= alloc_ptr + PW'(alloc);
            count_q   <= count_q + CW'(alloc) - free_n;
            pend_q    <= pend_q + CW'(alloc) - CW'(fill_hit);
            if (squash_all)
                for (int i = 0; i < DEPTH; i++) flags_q[i].squash <= 1'b1;
            if (fill_hit)
                flags_q[fill_ptr].filled <= 1'b1;
            if (alloc)
                flags_q[alloc_ptr] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc)
            pc_q[alloc_ptr] <= alloc_pc;
        if (fill_hit)
            instr_q[fill_ptr] <= fill_data;
    end

    assign head_pc      = pc_q[head_ptr];
    assign head_instr   = instr_q[head_ptr];
    assign head_filled  = flags_q[head_ptr].filled;
    assign head_squash  = flags_q[head_ptr].squash;
    assign fill_pending = (pend_q != '0);
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);

    // A response with nothing outstanding is dropped by the logic above.
    rsp_without_request: assert property (@(posedge clk) disable iff (rst)
        fill |-> (pend_q != '0))
        else $warning("ifetch_queue: response with no outstanding request ignored");

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch stage between the PC and the IF/ID pipeline register.
// Optional build macro: IFETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
// Ports:
//   clk, rst                      clock, async active-high reset
//   pc, pc_running                fetch address and run enable from the PC
//   stall_D, flush                IF/ID hold, redirect this cycle
//   imem_req_valid/addr/ready     request channel to instruction memory
//   imem_rsp_valid/data           in-order response channel, no back-pressure
//   keep_PC                       PC must hold (request not accepted)
//   instr_D, pc_D, pc_plus4_D, valid_D   IF/ID register
//
// state | meaning
// IDLE  | out of reset, waiting for pc_running
// RUN   | issuing requests and retiring responses
// FLUSH | redirect taken; waiting for squashed responses to drain
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(ifetch_pkg::NOP_INSTR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            pc_running,
    input  logic            stall_D,
    input  logic            flush,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            keep_PC,
    output logic [XLEN-1:0] instr_D,
    output logic [XLEN-1:0] pc_D,
    output logic [XLEN-1:0] pc_plus4_D,
    output logic            valid_D
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    ifetch_state_t   state_q, state_d;
    logic            alloc, pop, bypass, head_ok;
    logic [XLEN-1:0] head_pc, head_instr, load_instr;
    logic            head_filled, head_squash, fill_pending, q_full, q_empty;

    assign imem_req_valid = (state_q == RUN) & pc_running & ~flush & ~q_full;
    assign imem_req_addr  = pc;
    assign alloc          = imem_req_valid & imem_req_ready;
    assign keep_PC        = ~alloc;

    // An unfilled head is exactly the entry this cycle's response fills,
    // so the response can go straight into IF/ID.
    assign bypass     = imem_rsp_valid & fill_pending & ~q_empty & ~head_filled & ~head_squash;
    assign head_ok    = ~q_empty & ~head_squash & (head_filled | bypass);
    assign load_instr = head_filled ? head_instr : imem_rsp_data;
    assign pop        = head_ok & ~stall_D & ~flush;

    ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) u_queue (
        .clk          (clk),
        .rst          (rst),
        .alloc        (alloc),
        .alloc_pc     (pc),
        .fill         (imem_rsp_valid),
        .fill_data    (imem_rsp_data),
        .pop          (pop),
        .squash_all   (flush),
        .head_pc      (head_pc),
        .head_instr   (head_instr),
        .head_filled  (head_filled),
        .head_squash  (head_squash),
        .fill_pending (fill_pending),
        .full         (q_full),
        .empty        (q_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pc_running) state_d = RUN;
            RUN:     if (flush) state_d = FLUSH;
            FLUSH:   if (!flush && !(~q_empty & head_squash)) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_D    <= 1'b0;
            instr_D    <= NOP_INSTR;
            pc_D       <= '0;
            pc_plus4_D <= XLEN'(4);
        end else if (flush) begin
            valid_D <= 1'b0;
            instr_D <= NOP_INSTR;
        end else if (!stall_D) begin
            if (head_ok) begin
                valid_D    <= 1'b1;
                instr_D    <= load_instr;
                pc_D       <= head_pc;
                pc_plus4_D <= head_pc + XLEN'(4);
            end else begin
                valid_D <= 1'b0;
                instr_D <= NOP_INSTR;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (pop)                         perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state_q == RUN && keep_PC)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        pc_running = 1'b0;
    logic        stall_D = 1'b0;
    logic        flush = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        keep_PC;
    logic [31:0] instr_D, pc_D, pc_plus4_D;
    logic        valid_D;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    ifetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_running     (pc_running),
        .stall_D        (stall_D),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .keep_PC        (keep_PC),
        .instr_D        (instr_D),
        .pc_D           (pc_D),
        .pc_plus4_D     (pc_plus4_D),
        .valid_D        (valid_D)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (valid_D !== 1'b0) begin miscompares++; $display("FAIL reset_valid_D got %0b want 0", valid_D); end
        vectors++; if (instr_D !== NOP) begin miscompares++; $display("FAIL reset_instr_D got %h want %h", instr_D, NOP); end
        vectors++; if (pc_D !== 32'h0) begin miscompares++; $display("FAIL reset_pc_D got %h want 0", pc_D); end
        vectors++; if (pc_plus4_D !== 32'h4) begin miscompares++; $display("FAIL reset_pc_plus4_D got %h want 4", pc_plus4_D); end
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid got %0b want 0", imem_req_valid); end
        vectors++; if (keep_PC !== 1'b1) begin miscompares++; $display("FAIL reset_keep_PC got %0b want 1", keep_PC); end
        rst = 1'b0;
    endtask

    task automatic test_boot();
        tick();
        pc_running = 1'b1; pc = 32'h0; imem_req_ready = 1'b1;
        #1;
        vectors++; if (keep_PC !== 1'b1) begin miscompares++; $display("FAIL boot_idle_keep got %0b want 1", keep_PC); end
        tick();
        vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL boot_req_valid got %0b want 1", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL boot_req_addr got %h want 0", imem_req_addr); end
        vectors++; if (keep_PC !== 1'b0) begin miscompares++; $display("FAIL boot_keep_accept0 got %0b want 0", keep_PC); end
        tick();
        pc = 32'h4; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A0_0093;
        #1;
        vectors++; if (keep_PC !== 1'b0) begin miscompares++; $display("FAIL boot_keep_accept1 got %0b want 0", keep_PC); end
        vectors++; if (imem_req_addr !== 32'h4) begin miscompares++; $display("FAIL boot_req_addr1 got %h want 4", imem_req_addr); end
        tick();
        vectors++; if (valid_D !== 1'b1) begin miscompares++; $display("FAIL boot_valid_D got %0b want 1", valid_D); end
        vectors++; if (instr_D !== 32'h00A0_0093) begin miscompares++; $display("FAIL boot_instr_D got %h want 00a00093", instr_D); end
        vectors++; if (pc_D !== 32'h0) begin miscompares++; $display("FAIL boot_pc_D got %h want 0", pc_D); end
        vectors++; if (pc_plus4_D !== 32'h4) begin miscompares++; $display("FAIL boot_pc_plus4_D got %h want 4", pc_plus4_D); end
        pc_running = 1'b0; imem_rsp_data = 32'h0040_0113;
        #1;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL boot_stop_req got %0b want 0", imem_req_valid); end
        tick();
        vectors++; if (valid_D !== 1'b1 || pc_D !== 32'h4 || pc_plus4_D !== 32'h8 || instr_D !== 32'h0040_0113) begin
            miscompares++; $display("FAIL boot_second got v=%0b pc=%h pc4=%h ins=%h want v=1 pc=4 pc4=8 ins=00400113", valid_D, pc_D, pc_plus4_D, instr_D); end
        imem_rsp_valid = 1'b0;
        tick();
        vectors++; if (valid_D !== 1'b0 || instr_D !== NOP || pc_D !== 32'h4) begin
            miscompares++; $display("FAIL boot_bubble got v=%0b ins=%h pc=%h want v=0 ins=%h pc=4", valid_D, instr_D, pc_D, NOP); end
    endtask

    task automatic test_backpressure();
        pc = 32'h8; pc_running = 1'b1; imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (imem_req_valid !== 1'b1 || keep_PC !== 1'b1 || imem_req_addr !== 32'h8) begin
                miscompares++; $display("FAIL bp_cycle%0d got valid=%0b keep=%0b addr=%h want 1 1 8", i, imem_req_valid, keep_PC, imem_req_addr); end
            tick();
        end
    endtask

    task automatic test_full_latency4();
        imem_req_ready = 1'b1;
        #1;
        vectors++; if (keep_PC !== 1'b0) begin miscompares++; $display("FAIL full_accept0 got keep=%0b want 0 (allocation during back-pressure)", keep_PC); end
        tick();
        pc = 32'hC;
        #1;
        vectors++; if (imem_req_valid !== 1'b1 || keep_PC !== 1'b0) begin
            miscompares++; $display("FAIL full_accept1 got valid=%0b keep=%0b want 1 0", imem_req_valid, keep_PC); end
        tick();
        pc = 32'h10;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++; if (imem_req_valid !== 1'b0 || keep_PC !== 1'b1) begin
                miscompares++; $display("FAIL full_hold%0d got valid=%0b keep=%0b want 0 1", i, imem_req_valid, keep_PC); end
            tick();
        end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_8113;
        #1;
        vectors++; if (imem_req_valid !== 1'b0 || keep_PC !== 1'b1) begin
            miscompares++; $display("FAIL full_rsp_cycle got valid=%0b keep=%0b want 0 1", imem_req_valid, keep_PC); end
        tick();
        vectors++; if (valid_D !== 1'b1 || pc_D !== 32'h8 || instr_D !== 32'h0020_8113) begin
            miscompares++; $display("FAIL lat4_first got v=%0b pc=%h ins=%h want 1 8 00208113", valid_D, pc_D, instr_D); end
        imem_req_ready = 1'b0; imem_rsp_data = 32'h0031_0193;
        #1;
        vectors++; if (imem_req_valid !== 1'b1 || keep_PC !== 1'b1) begin
            miscompares++; $display("FAIL full_freed got valid=%0b keep=%0b want 1 1", imem_req_valid, keep_PC); end
        tick();
        vectors++; if (valid_D !== 1'b1 || pc_D !== 32'hC || pc_plus4_D !== 32'h10 || instr_D !== 32'h0031_0193) begin
            miscompares++; $display("FAIL lat4_second got v=%0b pc=%h pc4=%h ins=%h want 1 c 10 00310193", valid_D, pc_D, pc_plus4_D, instr_D); end
        imem_rsp_valid = 1'b0; pc_running = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        int n;
        pc = 32'h10; pc_running = 1'b1; imem_req_ready = 1'b1;
        tick();
        pc = 32'h14; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0100_0213;
        tick();
        vectors++; if (valid_D !== 1'b1 || pc_D !== 32'h10) begin
            miscompares++; $display("FAIL flush_pre got v=%0b pc=%h want 1 10", valid_D, pc_D); end
        pc = 32'h18; imem_rsp_valid = 1'b0; stall_D = 1'b1;
        tick();
        flush = 1'b1;
        #1;
        vectors++; if (imem_req_valid !== 1'b0 || keep_PC !== 1'b1) begin
            miscompares++; $display("FAIL flush_req got valid=%0b keep=%0b want 0 1", imem_req_valid, keep_PC); end
        tick();
        vectors++; if (valid_D !== 1'b0 || instr_D !== NOP || pc_D !== 32'h10) begin
            miscompares++; $display("FAIL flush_ifid got v=%0b ins=%h pc=%h want 0 %h 10", valid_D, instr_D, pc_D, NOP); end
        flush = 1'b0; stall_D = 1'b0; pc = 32'h100;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0001;
        #1;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL flush_state_req got %0b want 0", imem_req_valid); end
        tick();
        imem_rsp_data = 32'hDEAD_0002;
        tick();
        imem_rsp_valid = 1'b0;
        n = 0;
        #1;
        while (!imem_req_valid && n < 8) begin
            vectors++; if (valid_D !== 1'b0) begin miscompares++; $display("FAIL flush_discard got v=%0b pc=%h want v=0", valid_D, pc_D); end
            tick();
            #1;
            n++;
        end
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            miscompares++; $display("FAIL flush_resume got valid=%0b addr=%h want 1 100 (timeout)", imem_req_valid, imem_req_addr); end
        tick();
        pc_running = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0513;
        tick();
        vectors++; if (valid_D !== 1'b1 || pc_D !== 32'h100 || pc_plus4_D !== 32'h104 || instr_D !== 32'h0000_0513) begin
            miscompares++; $display("FAIL flush_target got v=%0b pc=%h pc4=%h ins=%h want 1 100 104 00000513", valid_D, pc_D, pc_plus4_D, instr_D); end
    endtask

    task automatic test_stall();
        stall_D = 1'b1; imem_rsp_valid = 1'b0;
        pc = 32'h4; pc_running = 1'b1; imem_req_ready = 1'b1;
        tick();
        pc = 32'h8; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_8093;
        tick();
        pc_running = 1'b0; imem_rsp_data = 32'h0021_0113;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (valid_D !== 1'b1 || pc_D !== 32'h100 || pc_plus4_D !== 32'h104 || instr_D !== 32'h0000_0513) begin
                miscompares++; $display("FAIL stall_hold%0d got v=%0b pc=%h pc4=%h ins=%h want 1 100 104 00000513", i, valid_D, pc_D, pc_plus4_D, instr_D); end
            tick();
            imem_rsp_valid = 1'b0;
        end
        stall_D = 1'b0;
        tick();
        vectors++; if (valid_D !== 1'b1 || pc_D !== 32'h4 || pc_plus4_D !== 32'h8 || instr_D !== 32'h0010_8093) begin
            miscompares++; $display("FAIL stall_order0 got v=%0b pc=%h pc4=%h ins=%h want 1 4 8 00108093", valid_D, pc_D, pc_plus4_D, instr_D); end
        tick();
        vectors++; if (valid_D !== 1'b1 || pc_D !== 32'h8 || pc_plus4_D !== 32'hC || instr_D !== 32'h0021_0113) begin
            miscompares++; $display("FAIL stall_order1 got v=%0b pc=%h pc4=%h ins=%h want 1 8 c 00210113", valid_D, pc_D, pc_plus4_D, instr_D); end
        tick();
        vectors++; if (valid_D !== 1'b0 || instr_D !== NOP || pc_D !== 32'h8) begin
            miscompares++; $display("FAIL stall_drain got v=%0b ins=%h pc=%h want 0 %h 8", valid_D, instr_D, pc_D, NOP); end
    endtask

    task automatic test_async_reset();
        pc = 32'h20; pc_running = 1'b1; imem_req_ready = 1'b1;
        tick();
        pc = 32'h24; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0293;
        tick();
        vectors++; if (valid_D !== 1'b1 || pc_D !== 32'h20) begin
            miscompares++; $display("FAIL arst_pre got v=%0b pc=%h want 1 20", valid_D, pc_D); end
        imem_rsp_valid = 1'b0; pc_running = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (valid_D !== 1'b0 || instr_D !== NOP || pc_D !== 32'h0 || pc_plus4_D !== 32'h4) begin
            miscompares++; $display("FAIL arst_ifid got v=%0b ins=%h pc=%h pc4=%h want 0 %h 0 4", valid_D, instr_D, pc_D, pc_plus4_D, NOP); end
        vectors++; if (imem_req_valid !== 1'b0 || keep_PC !== 1'b1) begin
            miscompares++; $display("FAIL arst_req got valid=%0b keep=%0b want 0 1", imem_req_valid, keep_PC); end
        tick();
        rst = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBADB_AD00;
        tick();
        imem_rsp_valid = 1'b0;
        vectors++; if (valid_D !== 1'b0 || instr_D !== NOP || pc_D !== 32'h0) begin
            miscompares++; $display("FAIL arst_stale got v=%0b ins=%h pc=%h want 0 %h 0", valid_D, instr_D, pc_D, NOP); end
        tick();
        vectors++; if (valid_D !== 1'b0 || imem_req_valid !== 1'b0) begin
            miscompares++; $display("FAIL arst_idle got v=%0b req=%0b want 0 0", valid_D, imem_req_valid); end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_backpressure();
        test_full_latency4();
        test_flush();
        test_stall();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Consumes `pc` / `pc_running` and issues in-order requests to instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers up to DEPTH in-flight fetches, then drives the IF/ID pipeline register (`instr_D`, `pc_D`, `pc_plus4_D`, `valid_D`).
- Returns `keep_PC` to the PC so it only advances when a request is accepted.

Parameters:
- XLEN, 32: address/instruction width.
- DEPTH, 2: in-flight entry queue depth; power of 2, ≥2.
- NOP_INSTR, 32'h0000_0013: value on `instr_D` when `valid_D`=0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- pc  in  XLEN  current fetch address from PC
- pc_running  in  1  PC in run state; no fetch while low
- stall_D  in  1  hazard unit holds IF/ID
- flush  in  1  redirect taken (branch_valid | jalr_M) this cycle
- imem_req_valid  out  1  request valid
- imem_req_addr  out  XLEN  request address (= pc)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid, in request order, no back-pressure
- imem_rsp_data  in  XLEN  fetched instruction
- keep_PC  out  1  PC must hold
- instr_D  out  XLEN  IF/ID instruction
- pc_D  out  XLEN  IF/ID pc
- pc_plus4_D  out  XLEN  IF/ID pc+4, wraps mod 2^XLEN
- valid_D  out  1  IF/ID holds a real instruction

Behaviour:

Reset:
- State=IDLE, queue empty, `valid_D`=0, `instr_D`=NOP_INSTR, `pc_D`=0, `pc_plus4_D`=4.
- `imem_req_valid`=0, `keep_PC`=1.

FSM:
- IDLE: go to RUN when `pc_running`=1.
- RUN: go to FLUSH on `flush`.
- FLUSH: go to RUN when no squashed entry remains outstanding; a new `flush` re-squashes and stays in FLUSH.

Queue:
- Circular buffer of DEPTH entries {pc, instr, filled, squash}, with alloc, fill and head pointers and an occupancy count of width clog2(DEPTH)+1.

Request:
- `imem_req_valid` = (state==RUN) & `pc_running` & !`flush` & (count<DEPTH).
- On request handshake: allocate an entry {pc, filled=0, squash=0}.
- `keep_PC` = !(valid & ready). PC-side branch priority overrides `keep_PC` on `flush`.

Response:
- Fills the oldest unfilled entry.
- If that entry is squashed, the data is discarded and the entry is freed the same cycle.
- A response with no outstanding entry is a protocol error: assert in simulation, ignore in RTL.

IF/ID load:
- Occurs when the head entry is filled and not squashed, `stall_D`=0, and `flush`=0.
- The load pops the head and sets `valid_D`=1 with {instr, pc, pc+4}.
- If `stall_D`=0 and no eligible head, the stage loads a bubble: `valid_D`=0, `instr_D`=NOP_INSTR; `pc_D` and `pc_plus4_D` hold.
- While `stall_D`=1, all IF/ID outputs hold.

Flush:
- Same cycle: all queued entries get `squash`=1; filled squashed entries are freed.
- Next edge: `valid_D`=0 and `instr_D`=NOP_INSTR, overriding `stall_D`.

Timing and boundary conditions:
- Latency: request accept at cycle N with a 1-cycle memory gives the response at N+1 and IF/ID valid at N+2.
- Full queue: no request, and `keep_PC`=1.
- Simultaneous alloc + free: count unchanged.
- Pointer wrap: modulo DEPTH.
- `pc_running` dropping mid-operation: no new requests; outstanding responses still drain normally.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- When defined, adds outputs `perf_fetch_cnt` [31:0] and `perf_stall_cnt` [31:0], both cleared by `rst`.
  - `perf_fetch_cnt` increments on each IF/ID load with `valid_D`←1.
  - `perf_stall_cnt` increments each RUN cycle with `keep_PC`=1.
  - Both counters wrap.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package `ifetch_pkg`: NOP_INSTR, the FSM state enum {IDLE, RUN, FLUSH}, and the queue entry struct.
- Sub-module `ifetch_queue`: the circular entry buffer with alloc/fill/pop/squash-all and count/full/empty.
- The FSM, handshake and IF/ID register live in the top module.

Test Plan:
- Boot: `rst` pulse, `pc_running`=1, pc=0, ready=1, 1-cycle memory returning 0x00A00093 → `valid_D`=1 two cycles later, `pc_D`=0, `pc_plus4_D`=4, and `keep_PC` low on accept cycles.
- Back-pressure: `imem_req_ready`=0 for 3 cycles → `keep_PC`=1, `imem_req_addr` holds 0x8, no allocation.
- Memory latency 4, DEPTH=2: after 2 accepts → queue full, `keep_PC`=1, `imem_req_valid`=0 until the first response arrives.
- Flush with 2 outstanding: `flush` pulse → next edge `valid_D`=0 and `instr_D`=0x00000013, both late responses discarded, and the first post-FLUSH `pc_D` equals the redirect target 0x100.
- `stall_D`=1 for 3 cycles while responses arrive → IF/ID outputs constant, queue holds, then loads in program order 0x4, 0x8.
- Async `rst` asserted mid-fetch, off the clock edge → outputs return to reset values immediately; a stale response after release is ignored.
